// File: rtl/byte_bus_arbiter.sv
// Round-robin arbiter serializing two 32-bit requesters onto a byte-wide memory bus.
// Latency: req in IDLE to ack takes 10+WAIT_CYCLES cycles; the loser holds req with ack low until its turn.
module byte_bus_arbiter #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic [7:0]  bus_out,
    input  logic [7:0]  bus_in,
    output logic        bus_oe,
    output logic        bus_sync,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3, S_CMD, S_WAIT,
        S_DATA0, S_DATA1, S_DATA2, S_DATA3, S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  bus_out_q, bus_out_d;
    logic        bus_oe_q, bus_oe_d;
    logic        bus_sync_q, bus_sync_d;
    logic        busy_q, busy_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        pick;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        shadow_d     = shadow_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        pick         = (req0 && req1) ? ~last_grant_q : req1;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    we_d         = pick ? we1    : we0;
                    addr_d       = pick ? addr1  : addr0;
                    wdata_d      = pick ? wdata1 : wdata0;
                    state_d      = S_ADDR0;
                end
            end
            S_ADDR0: state_d = S_ADDR1;
            S_ADDR1: state_d = S_ADDR2;
            S_ADDR2: state_d = S_ADDR3;
            S_ADDR3: state_d = S_CMD;
            S_CMD: begin
                cnt_d   = '0;
                state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA0;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_DATA0;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            S_DATA0: begin
                if (!we_q) shadow_d[7:0] = bus_in;
                state_d = S_DATA1;
            end
            S_DATA1: begin
                if (!we_q) shadow_d[15:8] = bus_in;
                state_d = S_DATA2;
            end
            S_DATA2: begin
                if (!we_q) shadow_d[23:16] = bus_in;
                state_d = S_DATA3;
            end
            S_DATA3: begin
                // Last byte bypasses the shadow so rdata is complete on entry to DONE.
                if (!we_q) begin
                    shadow_d[31:24] = bus_in;
                    rdata_d         = {bus_in, shadow_q[23:0]};
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        bus_out_d  = 8'h00;
        bus_oe_d   = 1'b0;
        bus_sync_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        busy_d     = (state_d != S_IDLE);
        unique case (state_d)
            S_ADDR0: begin bus_out_d = addr_d[7:0];   bus_oe_d = 1'b1; bus_sync_d = 1'b1; end
            S_ADDR1: begin bus_out_d = addr_d[15:8];  bus_oe_d = 1'b1; end
            S_ADDR2: begin bus_out_d = addr_d[23:16]; bus_oe_d = 1'b1; end
            S_ADDR3: begin bus_out_d = addr_d[31:24]; bus_oe_d = 1'b1; end
            S_CMD:   begin bus_out_d = {6'b0, grant_d, we_d}; bus_oe_d = 1'b1; end
            S_DATA0: if (we_d) begin bus_out_d = wdata_d[7:0];   bus_oe_d = 1'b1; end
            S_DATA1: if (we_d) begin bus_out_d = wdata_d[15:8];  bus_oe_d = 1'b1; end
            S_DATA2: if (we_d) begin bus_out_d = wdata_d[23:16]; bus_oe_d = 1'b1; end
            S_DATA3: if (we_d) begin bus_out_d = wdata_d[31:24]; bus_oe_d = 1'b1; end
            S_DONE:  begin ack0_d = ~grant_d; ack1_d = grant_d; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            shadow_q     <= '0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            bus_out_q    <= '0;
            bus_oe_q     <= 1'b0;
            bus_sync_q   <= 1'b0;
            busy_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            shadow_q     <= shadow_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            bus_out_q    <= bus_out_d;
            bus_oe_q     <= bus_oe_d;
            bus_sync_q   <= bus_sync_d;
            busy_q       <= busy_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata    = rdata_q;
    assign bus_out  = bus_out_q;
    assign bus_oe   = bus_oe_q;
    assign bus_sync = bus_sync_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// Directed bench for byte_bus_arbiter; one instance with WAIT_CYCLES=0, one with 2, sharing inputs.
module tb_byte_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [7:0]  bus_in = '0;

    logic        ack0, ack1, bus_oe, bus_sync, busy;
    logic [31:0] rdata;
    logic [7:0]  bus_out;
    logic        w_ack0, w_ack1, w_bus_oe, w_bus_sync, w_busy;
    logic [31:0] w_rdata;
    logic [7:0]  w_bus_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    byte_bus_arbiter #(.WAIT_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .bus_out(bus_out), .bus_in(bus_in),
        .bus_oe(bus_oe), .bus_sync(bus_sync), .busy(busy)
    );

    byte_bus_arbiter #(.WAIT_CYCLES(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(w_ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(w_ack1),
        .rdata(w_rdata), .bus_out(w_bus_out), .bus_in(bus_in),
        .bus_oe(w_bus_oe), .bus_sync(w_bus_sync), .busy(w_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; the sample point for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns into an IDLE cycle, which becomes cycle 0 of the next request.
    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; bus_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] wr_exp [0:8];
    logic [7:0] rd_in  [0:3];
    logic [7:0] w_in   [0:3];
    logic [7:0] drop_exp [0:3];

    initial begin
        wr_exp   = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
        rd_in    = '{8'h11, 8'h22, 8'h33, 8'h44};
        w_in     = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        drop_exp = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};

        // Reset state
        #2;
        chk("rst bus_out", {24'b0, bus_out}, 32'h0);
        chk("rst bus_oe", {31'b0, bus_oe}, 32'h0);
        chk("rst bus_sync", {31'b0, bus_sync}, 32'h0);
        chk("rst busy", {31'b0, busy}, 32'h0);
        chk("rst acks", {30'b0, ack1, ack0}, 32'h0);
        chk("rst rdata", rdata, 32'h0);

        // Write on port 0
        do_reset();
        we0 = 1'b1; addr0 = 32'h12345678; wdata0 = 32'hCAFEBABE; req0 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k <= 9) begin
                chk($sformatf("wr c%0d bus_out", k), {24'b0, bus_out}, {24'b0, wr_exp[k-1]});
                chk($sformatf("wr c%0d bus_oe", k), {31'b0, bus_oe}, 32'h1);
            end
            chk($sformatf("wr c%0d bus_sync", k), {31'b0, bus_sync}, {31'b0, k == 1});
            chk($sformatf("wr c%0d ack0", k), {31'b0, ack0}, {31'b0, k == 10});
            if (k == 10) req0 = 1'b0;
        end
        chk("wr c10 bus_oe", {31'b0, bus_oe}, 32'h0);
        step();
        chk("wr c11 busy", {31'b0, busy}, 32'h0);

        // Read on port 1
        do_reset();
        we1 = 1'b0; addr1 = 32'h00000010; req1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            bus_in = (k >= 6 && k <= 9) ? rd_in[k-6] : 8'h00;
            if (k == 1) chk("rd addr0", {24'b0, bus_out}, 32'h10);
            if (k == 2) chk("rd addr1", {24'b0, bus_out}, 32'h00);
            if (k == 5) begin
                chk("rd cmd", {24'b0, bus_out}, 32'h02);
                chk("rd cmd oe", {31'b0, bus_oe}, 32'h1);
            end
            if (k >= 6 && k <= 9) begin
                chk($sformatf("rd c%0d bus_oe", k), {31'b0, bus_oe}, 32'h0);
                chk($sformatf("rd c%0d bus_out", k), {24'b0, bus_out}, 32'h0);
            end
            chk($sformatf("rd c%0d ack0", k), {31'b0, ack0}, 32'h0);
            chk($sformatf("rd c%0d ack1", k), {31'b0, ack1}, {31'b0, k == 10});
            if (k == 10) begin
                chk("rd rdata", rdata, 32'h44332211);
                req1 = 1'b0;
            end
        end
        step();
        chk("rd rdata held", rdata, 32'h44332211);

        // Contention from reset, both requests held
        do_reset();
        we0 = 1'b1; addr0 = 32'h000000A0; wdata0 = 32'h01020304;
        we1 = 1'b0; addr1 = 32'h000000B0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("ct c%0d ack0", k), {31'b0, ack0}, {31'b0, k == 10 || k == 32});
            chk($sformatf("ct c%0d ack1", k), {31'b0, ack1}, {31'b0, k == 21});
            if (k == 5)  chk("ct cmd1", {24'b0, bus_out}, 32'h01);
            if (k == 16) chk("ct cmd2", {24'b0, bus_out}, 32'h02);
            if (k == 27) chk("ct cmd3", {24'b0, bus_out}, 32'h01);
            if (k == 11 || k == 22) chk($sformatf("ct c%0d idle", k), {31'b0, busy}, 32'h0);
            if (k == 12) chk("ct sync2 addr", {23'b0, bus_sync, bus_out}, 32'h1B0);
            if (k == 23) chk("ct sync3 addr", {23'b0, bus_sync, bus_out}, 32'h1A0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // WAIT_CYCLES=2 read on port 0 (second instance)
        do_reset();
        we0 = 1'b0; addr0 = 32'h00000040; req0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            bus_in = (k >= 8 && k <= 11) ? w_in[k-8] : 8'h00;
            if (k == 5) chk("wt cmd", {23'b0, w_bus_oe, w_bus_out}, 32'h100);
            if (k == 6 || k == 7) begin
                chk($sformatf("wt c%0d oe", k), {31'b0, w_bus_oe}, 32'h0);
                chk($sformatf("wt c%0d busy", k), {31'b0, w_busy}, 32'h1);
            end
            if (k >= 8 && k <= 11) chk($sformatf("wt c%0d oe", k), {31'b0, w_bus_oe}, 32'h0);
            chk($sformatf("wt c%0d ack0", k), {31'b0, w_ack0}, {31'b0, k == 12});
            if (k == 12) begin
                chk("wt rdata", w_rdata, 32'hD4C3B2A1);
                req0 = 1'b0;
            end
        end

        // Asynchronous reset during DATA1 of a write, req0 held throughout
        do_reset();
        we0 = 1'b1; addr0 = 32'h12345678; wdata0 = 32'hCAFEBABE; req0 = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        chk("ar data1", {23'b0, bus_oe, bus_out}, 32'h1BA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar bus_oe", {31'b0, bus_oe}, 32'h0);
        chk("ar busy", {31'b0, busy}, 32'h0);
        chk("ar ack0", {31'b0, ack0}, 32'h0);
        chk("ar bus_out", {24'b0, bus_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("ar held busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) chk("ar restart", {23'b0, bus_sync, bus_out}, 32'h178);
            chk($sformatf("ar c%0d ack0", k), {31'b0, ack0}, {31'b0, k == 10});
            if (k == 10) req0 = 1'b0;
        end

        // req0 dropped during ADDR2; frame must complete unchanged
        do_reset();
        we0 = 1'b1; addr0 = 32'h00000055; wdata0 = 32'h0F1E2D3C; req0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) begin
                req0 = 1'b0; wdata0 = 32'hFFFFFFFF; we0 = 1'b0;
            end
            if (k >= 6 && k <= 9)
                chk($sformatf("dr c%0d data", k), {23'b0, bus_oe, bus_out}, {23'b0, 1'b1, drop_exp[k-6]});
            chk($sformatf("dr c%0d ack0", k), {31'b0, ack0}, {31'b0, k == 10});
            if (k >= 11) chk($sformatf("dr c%0d busy", k), {31'b0, busy}, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
